// File: rtl/vga_mono_tint_pipe.sv
// Three-stage pipeline: BT.709 luma, frame-synchronous tint mode and truncation to DAC width.
// Optional ordered 2x2 dither before truncation when MONO_DITHER_EN is defined.
module vga_mono_tint_pipe #(
   parameter int   IN_W   = 6,
   parameter int   OUT_W  = 3,
   parameter logic HS_POL = 1'b0,
   parameter logic VS_POL = 1'b0
) (
   input  logic             clk_vga,
   input  logic             rst,
   input  logic [IN_W-1:0]  r_in,
   input  logic [IN_W-1:0]  g_in,
   input  logic [IN_W-1:0]  b_in,
   input  logic             hsync_in,
   input  logic             vsync_in,
   input  logic             de_in,
   input  logic [1:0]       mode_in,
   output logic [OUT_W-1:0] r_out,
   output logic [OUT_W-1:0] g_out,
   output logic [OUT_W-1:0] b_out,
   output logic             hsync_out,
   output logic             vsync_out,
   output logic             de_out,
   output logic [1:0]       mode_active
);

   localparam int   D       = IN_W - OUT_W;
   localparam logic HS_IDLE = ~HS_POL;
   localparam logic VS_IDLE = ~VS_POL;

   logic            vs_prev_q, vs_prev_d;
   logic [1:0]      mode_active_q, mode_active_d;
   logic            vs_edge;

   logic [IN_W-1:0] r1_q, g1_q, b1_q, r1_d, g1_d, b1_d;
   logic            hs1_q, vs1_q, de1_q, hs1_d, vs1_d, de1_d;
   logic [1:0]      mode1_q, mode1_d;

   logic [IN_W-1:0] r2_q, g2_q, b2_q, y2_q, r2_d, g2_d, b2_d, y2_d;
   logic            hs2_q, vs2_q, de2_q, hs2_d, vs2_d, de2_d;
   logic [1:0]      mode2_q, mode2_d;

   logic [OUT_W-1:0] r3_q, g3_q, b3_q, r3_d, g3_d, b3_d;
   logic             hs3_q, vs3_q, de3_q, hs3_d, vs3_d, de3_d;

   logic [IN_W+7:0] pr, pg, pb, psum;
   logic [IN_W-1:0] t_r, t_g, t_b;

`ifdef MONO_DITHER_EN
   localparam int DSH = (D >= 2) ? D - 2 : 0;
   logic            xpar_q, ypar_q, de_prev_q, xpar_d, ypar_d, de_prev_d;
   logic            xp1_q, yp1_q, xp2_q, yp2_q, xp1_d, yp1_d, xp2_d, yp2_d;
   logic [1:0]      k;
   logic [IN_W-1:0] off;

   function automatic logic [OUT_W-1:0] quant(input logic [IN_W-1:0] v,
                                              input logic [IN_W-1:0] o);
      logic [IN_W:0] s;
      s = {1'b0, v} + {1'b0, o};
      if (s[IN_W]) s = {1'b0, {IN_W{1'b1}}};
      return OUT_W'(s >> D);
   endfunction
`else
   function automatic logic [OUT_W-1:0] quant(input logic [IN_W-1:0] v);
      return OUT_W'(v >> D);
   endfunction
`endif

   always_comb begin
      // the pixel entering S1 on the edge cycle already uses the new mode
      vs_edge       = (vsync_in == VS_POL) && (vs_prev_q != VS_POL);
      vs_prev_d     = vsync_in;
      mode_active_d = vs_edge ? mode_in : mode_active_q;

      r1_d = r_in;  g1_d = g_in;  b1_d = b_in;
      hs1_d = hsync_in;  vs1_d = vsync_in;  de1_d = de_in;
      mode1_d = mode_active_d;

      pr   = {8'd0, r1_q} * (IN_W+8)'(54);
      pg   = {8'd0, g1_q} * (IN_W+8)'(183);
      pb   = {8'd0, b1_q} * (IN_W+8)'(19);
      psum = pr + pg + pb;
      y2_d = IN_W'(psum >> 8);
      r2_d = r1_q;  g2_d = g1_q;  b2_d = b1_q;
      hs2_d = hs1_q;  vs2_d = vs1_q;  de2_d = de1_q;
      mode2_d = mode1_q;

      case (mode2_q)
         2'b01:   begin t_r = '0;   t_g = y2_q;      t_b = '0;   end
         2'b10:   begin t_r = y2_q; t_g = y2_q >> 1; t_b = '0;   end
         2'b11:   begin t_r = y2_q; t_g = y2_q;      t_b = y2_q; end
         default: begin t_r = r2_q; t_g = g2_q;      t_b = b2_q; end
      endcase

`ifdef MONO_DITHER_EN
      xpar_d    = de_in ? ~xpar_q : 1'b0;
      de_prev_d = de_in;
      if (vs_edge)                  ypar_d = 1'b0;
      else if (de_prev_q && !de_in) ypar_d = ~ypar_q;
      else                          ypar_d = ypar_q;
      xp1_d = xpar_q;  yp1_d = ypar_q;
      xp2_d = xp1_q;   yp2_d = yp1_q;

      case ({yp2_q, xp2_q})
         2'b01:   k = 2'd2;
         2'b10:   k = 2'd3;
         2'b11:   k = 2'd1;
         default: k = 2'd0;
      endcase
      off = '0;
      if (D >= 2) off = IN_W'(k) << DSH;

      r3_d = de2_q ? quant(t_r, off) : '0;
      g3_d = de2_q ? quant(t_g, off) : '0;
      b3_d = de2_q ? quant(t_b, off) : '0;
`else
      r3_d = de2_q ? quant(t_r) : '0;
      g3_d = de2_q ? quant(t_g) : '0;
      b3_d = de2_q ? quant(t_b) : '0;
`endif
      hs3_d = hs2_q;  vs3_d = vs2_q;  de3_d = de2_q;
   end

   always_ff @(posedge clk_vga or posedge rst) begin
      if (rst) begin
         vs_prev_q <= VS_IDLE;  mode_active_q <= 2'b00;
         r1_q <= '0;  g1_q <= '0;  b1_q <= '0;  mode1_q <= 2'b00;
         hs1_q <= HS_IDLE;  vs1_q <= VS_IDLE;  de1_q <= 1'b0;
         r2_q <= '0;  g2_q <= '0;  b2_q <= '0;  y2_q <= '0;  mode2_q <= 2'b00;
         hs2_q <= HS_IDLE;  vs2_q <= VS_IDLE;  de2_q <= 1'b0;
         r3_q <= '0;  g3_q <= '0;  b3_q <= '0;
         hs3_q <= HS_IDLE;  vs3_q <= VS_IDLE;  de3_q <= 1'b0;
`ifdef MONO_DITHER_EN
         xpar_q <= 1'b0;  ypar_q <= 1'b0;  de_prev_q <= 1'b0;
         xp1_q <= 1'b0;  yp1_q <= 1'b0;  xp2_q <= 1'b0;  yp2_q <= 1'b0;
`endif
      end else begin
         vs_prev_q <= vs_prev_d;  mode_active_q <= mode_active_d;
         r1_q <= r1_d;  g1_q <= g1_d;  b1_q <= b1_d;  mode1_q <= mode1_d;
         hs1_q <= hs1_d;  vs1_q <= vs1_d;  de1_q <= de1_d;
         r2_q <= r2_d;  g2_q <= g2_d;  b2_q <= b2_d;  y2_q <= y2_d;  mode2_q <= mode2_d;
         hs2_q <= hs2_d;  vs2_q <= vs2_d;  de2_q <= de2_d;
         r3_q <= r3_d;  g3_q <= g3_d;  b3_q <= b3_d;
         hs3_q <= hs3_d;  vs3_q <= vs3_d;  de3_q <= de3_d;
`ifdef MONO_DITHER_EN
         xpar_q <= xpar_d;  ypar_q <= ypar_d;  de_prev_q <= de_prev_d;
         xp1_q <= xp1_d;  yp1_q <= yp1_d;  xp2_q <= xp2_d;  yp2_q <= yp2_d;
`endif
      end
   end

   assign r_out       = r3_q;
   assign g_out       = g3_q;
   assign b_out       = b3_q;
   assign hsync_out   = hs3_q;
   assign vsync_out   = vs3_q;
   assign de_out      = de3_q;
   assign mode_active = mode_active_q;

endmodule

// File: tb/tb_vga_mono_tint_pipe.sv
// Directed bench for vga_mono_tint_pipe (6->3 instance) plus an 8->8 luma sweep instance.
module tb_vga_mono_tint_pipe;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [5:0] r_in, g_in, b_in;
   logic       hs, vs, de;
   logic [1:0] mode;
   logic [2:0] r_out, g_out, b_out;
   logic       hs_out, vs_out, de_out;
   logic [1:0] mode_act;

   logic [7:0] r8, g8, b8, r8_out, g8_out, b8_out;
   logic       vs8, de8, hs8_out, vs8_out, de8_out;
   logic [1:0] mode8, mode8_act;

   int checks = 0;
   int failures = 0;
   logic [7:0] exp8 [0:999];

   vga_mono_tint_pipe #(.IN_W(6), .OUT_W(3), .HS_POL(1'b0), .VS_POL(1'b0)) dut (
      .clk_vga(clk), .rst(rst), .r_in(r_in), .g_in(g_in), .b_in(b_in),
      .hsync_in(hs), .vsync_in(vs), .de_in(de), .mode_in(mode),
      .r_out(r_out), .g_out(g_out), .b_out(b_out),
      .hsync_out(hs_out), .vsync_out(vs_out), .de_out(de_out), .mode_active(mode_act)
   );

   vga_mono_tint_pipe #(.IN_W(8), .OUT_W(8), .HS_POL(1'b0), .VS_POL(1'b0)) dut8 (
      .clk_vga(clk), .rst(rst), .r_in(r8), .g_in(g8), .b_in(b8),
      .hsync_in(1'b1), .vsync_in(vs8), .de_in(de8), .mode_in(mode8),
      .r_out(r8_out), .g_out(g8_out), .b_out(b8_out),
      .hsync_out(hs8_out), .vsync_out(vs8_out), .de_out(de8_out), .mode_active(mode8_act)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_rgb(input string tag, input logic [2:0] r, input logic [2:0] g,
                            input logic [2:0] b);
      check({tag, ".r"}, 32'(r_out), 32'(r));
      check({tag, ".g"}, 32'(g_out), 32'(g));
      check({tag, ".b"}, 32'(b_out), 32'(b));
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pix(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b);
      r_in = r;  g_in = g;  b_in = b;
   endtask

`ifdef MONO_DITHER_EN
   logic       dith_de  [0:7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
   logic [2:0] dith_exp [0:7] = '{3'd4, 3'd5, 3'd0, 3'd0, 3'd5, 3'd4, 3'd0, 3'd0};
`endif

   initial begin
      rst = 1'b1;  hs = 1'b1;  vs = 1'b1;  de = 1'b0;  mode = 2'b00;  pix(6'h0, 6'h0, 6'h0);
      r8 = '0;  g8 = '0;  b8 = '0;  vs8 = 1'b1;  de8 = 1'b0;  mode8 = 2'b00;
      tick(2);
      check_rgb("reset", 3'd0, 3'd0, 3'd0);
      check("reset.de", 32'(de_out), 32'd0);
      check("reset.hs", 32'(hs_out), 32'd1);
      check("reset.vs", 32'(vs_out), 32'd1);
      check("reset.mode", 32'(mode_act), 32'd0);
      rst = 1'b0;

`ifdef MONO_DITHER_EN
      mode = 2'b11;  pix(6'd36, 6'd36, 6'd36);
      tick(2);
      vs = 1'b0;
      tick(1);
      check("dith.mode", 32'(mode_act), 32'd3);
      for (int i = 0; i < 11; i++) begin
         de = (i < 8) ? dith_de[i] : 1'b0;
         if (i >= 3) check_rgb($sformatf("dith.px%0d", i - 3), dith_exp[i-3], dith_exp[i-3],
                               dith_exp[i-3]);
         tick(1);
      end
      pix(6'h3F, 6'h3F, 6'h3F);  de = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (i >= 3) check_rgb($sformatf("dith.sat%0d", i - 3), 3'd7, 3'd7, 3'd7);
         tick(1);
      end
      de = 1'b0;
`else
      // mode_in is ignored without a vsync edge
      mode = 2'b11;  de = 1'b1;  hs = 1'b0;  pix(6'h3F, 6'h20, 6'h08);
      tick(2);
      check("lat.hs_early", 32'(hs_out), 32'd1);
      check("lat.de_early", 32'(de_out), 32'd0);
      tick(1);
      check_rgb("pass", 3'd7, 3'd4, 3'd1);
      check("lat.hs", 32'(hs_out), 32'd0);
      check("lat.de", 32'(de_out), 32'd1);
      check("pass.mode", 32'(mode_act), 32'd0);
      hs = 1'b1;

      pix(6'h3F, 6'h3F, 6'h3F);  mode = 2'b01;
      tick(4);
      check("latch.before", 32'(mode_act), 32'd0);
      vs = 1'b0;
      tick(1);
      check("latch.edge", 32'(mode_act), 32'd1);
      tick(1);
      check("latch.old_px", 32'(r_out), 32'd7);
      check("latch.vs_early", 32'(vs_out), 32'd1);
      tick(1);
      check_rgb("green", 3'd0, 3'd7, 3'd0);
      check("latch.vs", 32'(vs_out), 32'd0);

      mode = 2'b10;
      tick(3);
      check("latch.held", 32'(mode_act), 32'd1);
      check_rgb("green.held", 3'd0, 3'd7, 3'd0);
      vs = 1'b1;
      tick(2);
      vs = 1'b0;
      tick(1);
      check("latch.amber", 32'(mode_act), 32'd2);
      tick(2);
      check_rgb("amber", 3'd7, 3'd3, 3'd0);

      vs = 1'b1;
      tick(1);
      mode = 2'b11;  vs = 1'b0;  pix(6'h00, 6'h3F, 6'h00);
      tick(3);
      check_rgb("white", 3'd5, 3'd5, 3'd5);
      check("white.mode", 32'(mode_act), 32'd3);

      de = 1'b0;  pix(6'h3F, 6'h3F, 6'h3F);
      tick(3);
      check_rgb("blank", 3'd0, 3'd0, 3'd0);
      check("blank.de", 32'(de_out), 32'd0);
      de = 1'b1;  hs = 1'b0;
      tick(3);
      check_rgb("unblank", 3'd7, 3'd7, 3'd7);

      rst = 1'b1;
      #1;
      check_rgb("rst_mid", 3'd0, 3'd0, 3'd0);
      check("rst_mid.hs", 32'(hs_out), 32'd1);
      check("rst_mid.vs", 32'(vs_out), 32'd1);
      check("rst_mid.de", 32'(de_out), 32'd0);
      check("rst_mid.mode", 32'(mode_act), 32'd0);
      tick(1);
      vs = 1'b1;  hs = 1'b1;  pix(6'h3F, 6'h20, 6'h08);
      rst = 1'b0;
      tick(3);
      check_rgb("refill", 3'd7, 3'd4, 3'd1);
      check("refill.mode", 32'(mode_act), 32'd0);
      de = 1'b0;
`endif

      mode8 = 2'b11;  vs8 = 1'b0;
      tick(1);
      vs8 = 1'b1;  de8 = 1'b1;
      check("sweep.mode", 32'(mode8_act), 32'd3);
      for (int i = 0; i < 1003; i++) begin
         if (i < 1000) begin
            int rv, gv, bv;
            rv = (i == 0) ? 255 : int'($urandom_range(255));
            gv = (i == 0) ? 255 : int'($urandom_range(255));
            bv = (i == 0) ? 255 : int'($urandom_range(255));
            r8 = 8'(rv);  g8 = 8'(gv);  b8 = 8'(bv);
            exp8[i] = 8'((54 * rv + 183 * gv + 19 * bv) >> 8);
         end
         if (i >= 3) begin
            check("sweep.r", 32'(r8_out), 32'(exp8[i-3]));
            check("sweep.g", 32'(g8_out), 32'(exp8[i-3]));
            check("sweep.b", 32'(b8_out), 32'(exp8[i-3]));
         end
         tick(1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
